// File: rtl/spi_xfer_ctrl.sv
// Byte-level SPI sequencer: one start/done handshake per byte, MSB first, two selectable devices.
// Optional `SPI_RXSYNC_EN adds a 2-flop MISO synchroniser and samples on the last LEAD cycle.
`timescale 1ns/1ps
module spi_xfer_ctrl #(
   parameter int unsigned CLKDIV = 4
) (
   input  logic       CLK,
   input  logic       nRESET,
   input  logic       start,
   input  logic       dev,
   input  logic       cpol,
   input  logic       keep_ss,
   input  logic [7:0] txd,
   output logic       ready,
   output logic       done,
   output logic [7:0] rxd,
   output logic       SCK,
   output logic       MOSI,
   output logic       nSS0,
   output logic       nSS1,
   input  logic       MISO0,
   input  logic       MISO1
);

   localparam int unsigned CW = $clog2(CLKDIV) + 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(CLKDIV - 1);

   typedef enum logic [2:0] {IDLE, SETUP, LEAD, TRAIL, HOLD, FIN} state_t;

   state_t        state, state_nx;
   logic [CW-1:0] cnt;
   logic [2:0]    bit_idx;
   logic [6:0]    tx_sh;
   logic [7:0]    rx_sh;
   logic          dev_r, cpol_r, keep_r;
   logic          accept, enter_lead, enter_trail, finish;
   logic          phase_end, miso_sel;

   assign phase_end = (cnt == CNT_LAST);
   assign ready     = (state == IDLE);

`ifdef SPI_RXSYNC_EN
   logic [1:0] sync0, sync1;

   if (CLKDIV < 3) begin : g_clkdiv_check
      $error("spi_xfer_ctrl: CLKDIV must be >= 3 when SPI_RXSYNC_EN is defined");
   end

   always_ff @(posedge CLK or negedge nRESET) begin
      if (!nRESET) begin
         sync0 <= '0;
         sync1 <= '0;
      end else begin
         sync0 <= {sync0[0], MISO0};
         sync1 <= {sync1[0], MISO1};
      end
   end

   assign miso_sel = dev_r ? sync1[1] : sync0[1];
`else
   assign miso_sel = dev_r ? MISO1 : MISO0;
`endif

   always_ff @(posedge CLK or negedge nRESET) begin
      if (!nRESET) state <= IDLE;
      else         state <= state_nx;
   end

   always_comb begin
      state_nx    = state;
      accept      = 1'b0;
      enter_lead  = 1'b0;
      enter_trail = 1'b0;
      finish      = 1'b0;
      case (state)
         IDLE:  if (start) begin
                   accept   = 1'b1;
                   state_nx = SETUP;
                end
         SETUP: if (phase_end) begin
                   enter_lead = 1'b1;
                   state_nx   = LEAD;
                end
         LEAD:  if (phase_end) begin
                   enter_trail = 1'b1;
                   state_nx    = TRAIL;
                end
         TRAIL: if (phase_end) begin
                   if (bit_idx == 3'd0) state_nx = HOLD;
                   else begin
                      enter_lead = 1'b1;
                      state_nx   = LEAD;
                   end
                end
         HOLD:  if (phase_end) state_nx = FIN;
         // FIN is the single extra cycle that places done on edge 18*CLKDIV+1
         FIN: begin
                   finish   = 1'b1;
                   state_nx = IDLE;
                end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge nRESET) begin
      if (!nRESET) begin
         cnt     <= '0;
         bit_idx <= '0;
         tx_sh   <= '0;
         rx_sh   <= '0;
         dev_r   <= 1'b0;
         cpol_r  <= 1'b0;
         keep_r  <= 1'b0;
         rxd     <= '0;
         done    <= 1'b0;
         SCK     <= 1'b0;
         MOSI    <= 1'b1;
         nSS0    <= 1'b1;
         nSS1    <= 1'b1;
      end else begin
         done <= finish;
         if (accept) begin
            dev_r   <= dev;
            cpol_r  <= cpol;
            keep_r  <= keep_ss;
            tx_sh   <= txd[6:0];
            MOSI    <= txd[7];
            SCK     <= cpol;
            nSS0    <= dev;
            nSS1    <= !dev;
            cnt     <= '0;
            bit_idx <= 3'd7;
         end else if (state != IDLE) begin
            cnt <= (state_nx != state) ? '0 : cnt + 1'b1;
         end
         if (enter_lead) SCK <= !cpol_r;
         if (enter_trail) begin
            SCK <= cpol_r;
            if (bit_idx != 3'd0) begin
               MOSI  <= tx_sh[6];
               tx_sh <= {tx_sh[5:0], 1'b0};
            end
         end
         if (state == TRAIL && phase_end && bit_idx != 3'd0) bit_idx <= bit_idx - 1'b1;
`ifdef SPI_RXSYNC_EN
         if (state == LEAD && phase_end) rx_sh <= {rx_sh[6:0], miso_sel};
`else
         if (enter_lead) rx_sh <= {rx_sh[6:0], miso_sel};
`endif
         if (finish) begin
            rxd  <= rx_sh;
            MOSI <= 1'b1;
            if (!keep_r) begin
               nSS0 <= 1'b1;
               nSS1 <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Scoreboard bench for spi_xfer_ctrl: driver pushes expected bytes, monitor checks each done.
`timescale 1ns/1ps
module tb_spi_xfer_ctrl;
`ifdef SPI_RXSYNC_EN
   localparam int unsigned DIV = 3;
   localparam logic [7:0]  EXP_TOG = 8'hAA;
`else
   localparam int unsigned DIV = 2;
   localparam logic [7:0]  EXP_TOG = 8'h55;
`endif
   localparam int LAT = 18 * DIV + 1;

   logic       clk = 1'b0, rst_n = 1'b1;
   logic       start = 1'b0, dev = 1'b0, cpol = 1'b0, keep_ss = 1'b0;
   logic [7:0] txd = 8'h00;
   logic       ready, done, sck, mosi, nss0, nss1;
   logic [7:0] rxd;
   logic       loop0 = 1'b0, miso0_t = 1'b0, miso1 = 1'b0, tog_en = 1'b0;
   logic       miso0;

   assign miso0 = loop0 ? mosi : miso0_t;

   always #5 clk = ~clk;

   spi_xfer_ctrl #(.CLKDIV(DIV)) u_dut (
      .CLK(clk), .nRESET(rst_n), .start(start), .dev(dev), .cpol(cpol),
      .keep_ss(keep_ss), .txd(txd), .ready(ready), .done(done), .rxd(rxd),
      .SCK(sck), .MOSI(mosi), .nSS0(nss0), .nSS1(nss1),
      .MISO0(miso0), .MISO1(miso1)
   );

   typedef struct {
      logic [7:0] rx;
      logic [7:0] tx;
      int         acc;
      logic       n0;
      logic       n1;
   } exp_t;

   exp_t       exp_q[$];
   int         n_cmp = 0, n_bad = 0;
   int         cyc = 0;
   int         lead_tot = 0;
   logic [7:0] lead_mosi = 8'h00;
   logic       cpol_cur = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   // leading SCK edges and the MOSI value they launch
   initial forever begin
      @(sck);
      if (sck !== cpol_cur) begin
         lead_tot++;
         lead_mosi = {lead_mosi[6:0], mosi};
      end
   end

   initial forever begin
      @(posedge sck);
      if (tog_en) begin
         #1;
         miso0_t = ~miso0_t;
      end
   end

   initial begin
      int   base;
      exp_t e;
      base = 0;
      forever begin
         @(negedge clk);
         if (!rst_n) base = lead_tot;
         else if (done) begin
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_done: got done=1 expected no done (rxd=%0h)", rxd);
            end else begin
               e = exp_q.pop_front();
               check("rxd", rxd, e.rx);
               check("done_latency", cyc - e.acc, LAT);
               check("nss0_at_done", nss0, e.n0);
               check("nss1_at_done", nss1, e.n1);
               check("lead_edges", lead_tot - base, 8);
               check("mosi_serial", lead_mosi, e.tx);
               check("ready_at_done", ready, 1);
            end
            base = lead_tot;
         end
      end
   end

   task automatic send(input logic d, input logic cp, input logic k, input logic [7:0] t,
                       input logic [7:0] exp_rx, input bit push, output int acc);
      int w;
      w = 0;
      acc = -1;
      @(negedge clk);
      while (!ready && w < 4 * LAT) begin
         @(negedge clk);
         w++;
      end
      if (!ready) begin
         n_cmp++;
         n_bad++;
         $display("FAIL ready_timeout: got ready=0 expected ready=1 within %0d cycles", 4 * LAT);
         return;
      end
      dev = d; cpol = cp; cpol_cur = cp; keep_ss = k; txd = t; start = 1'b1;
      acc = cyc + 1;
      if (push) exp_q.push_back('{rx: exp_rx, tx: t, acc: cyc + 1,
                                  n0: k ? d : 1'b1, n1: k ? !d : 1'b1});
      @(posedge clk);
      #1;
      start = 1'b0;
      check("ready_after_accept", ready, 0);
      check("nss_selected_low", d ? nss1 : nss0, 0);
      check("nss_other_high", d ? nss0 : nss1, 1);
   endtask

   task automatic wait_idle();
      int w;
      w = 0;
      while (exp_q.size() != 0 && w < 4 * LAT) begin
         @(negedge clk);
         w++;
      end
      if (exp_q.size() != 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL done_timeout: got %0d pending expected 0 pending", exp_q.size());
         exp_q.delete();
      end
      repeat (2) @(negedge clk);
   endtask

   initial begin
      int a1, a2, a3, w;
      #2 rst_n = 1'b0;
      #1;
      check("rst_sck", sck, 0);
      check("rst_mosi", mosi, 1);
      check("rst_nss0", nss0, 1);
      check("rst_nss1", nss1, 1);
      check("rst_ready", ready, 1);
      check("rst_done", done, 0);
      check("rst_rxd", rxd, 8'h00);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      // loopback A5 on SPI0, cpol=0
      loop0 = 1'b1;
      send(1'b0, 1'b0, 1'b0, 8'hA5, 8'hA5, 1'b1, a1);
      wait_idle();

      // reset in the middle of a byte while SCK is high and MOSI is low
      send(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, a1);
      w = 0;
      while (sck !== 1'b1 && w < 4 * LAT) begin
         @(negedge clk);
         w++;
      end
      check("midbyte_sck_high", sck, 1);
      rst_n = 1'b0;
      #1;
      check("midrst_sck", sck, 0);
      check("midrst_mosi", mosi, 1);
      check("midrst_nss0", nss0, 1);
      check("midrst_nss1", nss1, 1);
      check("midrst_ready", ready, 1);
      check("midrst_rxd", rxd, 8'h00);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // SPI1, cpol=1, MISO1 stuck high
      loop0 = 1'b0;
      miso1 = 1'b1;
      send(1'b1, 1'b1, 1'b0, 8'h3C, 8'hFF, 1'b1, a1);
      wait_idle();
      check("sck_idle_cpol1", sck, 1);

      // back-to-back with keep_ss on SPI0
      loop0 = 1'b1;
      send(1'b0, 1'b0, 1'b1, 8'h01, 8'h01, 1'b1, a1);
      send(1'b0, 1'b0, 1'b1, 8'h80, 8'h80, 1'b1, a2);
      send(1'b0, 1'b0, 1'b0, 8'h7E, 8'h7E, 1'b1, a3);
      check("b2b_accept_12", a2 - a1, LAT + 1);
      check("b2b_accept_23", a3 - a2, LAT + 1);
      wait_idle();

      // start pulses while busy must be dropped
      send(1'b0, 1'b0, 1'b0, 8'h5A, 8'h5A, 1'b1, a1);
      repeat (3) @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         txd = 8'hFF;
         start = 1'b1;
         @(negedge clk);
         start = 1'b0;
         repeat (2) @(negedge clk);
      end
      wait_idle();
      repeat (LAT + 5) @(negedge clk);

      // keep_ss on SPI0, then switch to SPI1
      send(1'b0, 1'b0, 1'b1, 8'hC3, 8'hC3, 1'b1, a1);
      miso1 = 1'b0;
      send(1'b1, 1'b0, 1'b0, 8'h96, 8'h00, 1'b1, a2);
      wait_idle();

      // MISO0 toggles just after each leading edge
      loop0 = 1'b0;
      tog_en = 1'b1;
      send(1'b0, 1'b0, 1'b0, 8'h00, EXP_TOG, 1'b1, a1);
      wait_idle();
      tog_en = 1'b0;

      repeat (5) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: got no finish expected finish before 500000ns");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
      $fatal(1, "timeout");
   end

endmodule
